// File: rtl/reg_context_unit_pkg.sv
// Shared constants, FSM state encoding and mask helper for the register save/restore sequencer.
package reg_context_unit_pkg;

    localparam int REG_COUNT      = 8;
    localparam int REG_SEL_W      = 3;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RF_RD,
        ST_RF_CAP,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_RF_WR,
        ST_FIN
    } ctx_state_e;

    function automatic logic [REG_COUNT-1:0] clear_bit(input logic [REG_COUNT-1:0] mask,
                                                       input logic [REG_SEL_W-1:0] idx);
        clear_bit = mask & ~(REG_COUNT'(1) << idx);
    endfunction

endpackage

// File: rtl/reg_context_unit_if.sv
// Register-file rD port and data-memory bus as seen by the context sequencer.
interface reg_context_unit_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  rf_en;
    logic                  rf_wr_en;
    logic [2:0]            rf_sel;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [15:0]           mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output rf_en, rf_wr_en, rf_sel, rf_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_rdata, mem_rdata, mem_ack
    );

    modport slave (
        input  rf_en, rf_wr_en, rf_sel, rf_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output rf_rdata, mem_rdata, mem_ack
    );
endinterface

// File: rtl/reg_context_unit_prio_enc.sv
// ctx_prio_enc: 8-bit priority encoder, high_first_i selects highest-set-bit-first order.
module ctx_prio_enc
    import reg_context_unit_pkg::*;
(
    input  logic [REG_COUNT-1:0] req_i,
    input  logic                 high_first_i,
    output logic [REG_SEL_W-1:0] idx_o,
    output logic                 any_o
);

    logic [REG_COUNT-1:0] lo_win;
    logic [REG_COUNT-1:0] hi_win;
    logic [REG_COUNT-1:0] win;

    // One-hot winner per direction: a bit wins if no bit ahead of it in scan order is set.
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_win
            if (gi == 0) begin : g_lo_first
                assign lo_win[gi] = req_i[gi];
            end else begin : g_lo_rest
                assign lo_win[gi] = req_i[gi] && !(|req_i[gi-1:0]);
            end
            if (gi == REG_COUNT - 1) begin : g_hi_first
                assign hi_win[gi] = req_i[gi];
            end else begin : g_hi_rest
                assign hi_win[gi] = req_i[gi] && !(|req_i[REG_COUNT-1:gi+1]);
            end
        end
    endgenerate

    assign win   = high_first_i ? hi_win : lo_win;
    assign any_o = |req_i;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (win[i]) begin
                idx_o = idx_o | REG_SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_context_unit.sv
// Register save/restore sequencer: pushes/pops masked registers between the rD port and memory.
// Optional CTX_FRAME_WORD_EN adds a {8'h00, mask} header word to each saved frame.
module reg_context_unit
    import reg_context_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SP_STEP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_save,
    input  logic                  start_restore,
    input  logic [REG_COUNT-1:0]  reg_mask,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sp_out,
    reg_context_unit_if.master    bus
);

`ifdef CTX_FRAME_WORD_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    ctx_state_e            state_q;
    logic                  save_op_q;
    logic [REG_COUNT-1:0]  mask_q;
    logic [REG_COUNT-1:0]  orig_mask_q;
    logic                  hdr_pend_q;
    logic                  hdr_rd_q;
    logic [ADDR_WIDTH-1:0] sp_q;
    logic [REG_SEL_W-1:0]  idx_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] sp_out_q;
    logic                  rf_en_q;
    logic                  rf_wr_en_q;
    logic [REG_SEL_W-1:0]  rf_sel_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic [REG_SEL_W-1:0]  enc_idx;
    logic                  enc_any;
    logic [ADDR_WIDTH-1:0] sp_dec_d;
    logic [ADDR_WIDTH-1:0] sp_inc_d;

    assign sp_dec_d = sp_q - ADDR_WIDTH'(SP_STEP);
    assign sp_inc_d = sp_q + ADDR_WIDTH'(SP_STEP);

    // Save walks r7..r0, restore walks r0..r7, so the stack stays LIFO.
    ctx_prio_enc u_prio_enc (
        .req_i        (mask_q),
        .high_first_i (save_op_q),
        .idx_o        (enc_idx),
        .any_o        (enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            save_op_q   <= 1'b0;
            mask_q      <= '0;
            orig_mask_q <= '0;
            hdr_pend_q  <= 1'b0;
            hdr_rd_q    <= 1'b0;
            sp_q        <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sp_out_q    <= '0;
            rf_en_q     <= 1'b0;
            rf_wr_en_q  <= 1'b0;
            rf_sel_q    <= '0;
            rf_wdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_save || start_restore) begin
                        save_op_q   <= start_save;
                        mask_q      <= reg_mask;
                        orig_mask_q <= reg_mask;
                        hdr_pend_q  <= FRAME_EN;
                        sp_q        <= sp_in;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (FRAME_EN && hdr_pend_q && !save_op_q) begin
                        // Restore pops the header first; its low byte becomes the mask.
                        hdr_pend_q <= 1'b0;
                        hdr_rd_q   <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= sp_q;
                        state_q    <= ST_MEM_RD;
                    end else if (enc_any) begin
                        mask_q <= clear_bit(mask_q, enc_idx);
                        idx_q  <= enc_idx;
                        if (save_op_q) begin
                            rf_en_q  <= 1'b1;
                            rf_sel_q <= enc_idx;
                            state_q  <= ST_RF_RD;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= sp_q;
                            state_q    <= ST_MEM_RD;
                        end
                    end else if (FRAME_EN && hdr_pend_q) begin
                        hdr_pend_q  <= 1'b0;
                        sp_q        <= sp_dec_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= sp_dec_d;
                        mem_wdata_q <= DATA_WIDTH'(orig_mask_q);
                        state_q     <= ST_MEM_WR;
                    end else begin
                        done_q   <= 1'b1;
                        sp_out_q <= sp_q;
                        state_q  <= ST_FIN;
                    end
                end
                ST_RF_RD: begin
                    rf_en_q <= 1'b0;
                    state_q <= ST_RF_CAP;
                end
                ST_RF_CAP: begin
                    sp_q        <= sp_dec_d;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= sp_dec_d;
                    mem_wdata_q <= bus.rf_rdata;
                    state_q     <= ST_MEM_WR;
                end
                ST_MEM_WR: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_SCAN;
                    end
                end
                ST_MEM_RD: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        sp_q      <= sp_inc_d;
                        if (hdr_rd_q) begin
                            hdr_rd_q <= 1'b0;
                            mask_q   <= bus.mem_rdata[REG_COUNT-1:0];
                            state_q  <= ST_SCAN;
                        end else begin
                            rf_en_q    <= 1'b1;
                            rf_wr_en_q <= 1'b1;
                            rf_sel_q   <= idx_q;
                            rf_wdata_q <= bus.mem_rdata;
                            state_q    <= ST_RF_WR;
                        end
                    end
                end
                ST_RF_WR: begin
                    rf_en_q    <= 1'b0;
                    rf_wr_en_q <= 1'b0;
                    state_q    <= ST_SCAN;
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sp_out        = sp_out_q;
    assign bus.rf_en     = rf_en_q;
    assign bus.rf_wr_en  = rf_wr_en_q;
    assign bus.rf_sel    = rf_sel_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_reg_context_unit.sv
// Scoreboard bench for reg_context_unit: memory/register-file models plus per-scenario tasks.
module tb_reg_context_unit;

`ifdef CTX_FRAME_WORD_EN
    localparam bit FRAME = 1'b1;
`else
    localparam bit FRAME = 1'b0;
`endif
    localparam int HDR = FRAME ? 1 : 0;

    typedef logic [33:0] ev_t;  // {kind, addr_or_sel, data}: 1=mem write, 2=mem read, 3=rf write

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_save = 1'b0;
    logic        start_restore = 1'b0;
    logic [7:0]  reg_mask = 8'h00;
    logic [15:0] sp_in = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] sp_out;

    reg_context_unit_if #(.DATA_WIDTH(16)) bus_if ();

    reg_context_unit #(.DATA_WIDTH(16), .SP_STEP(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_save    (start_save),
        .start_restore (start_restore),
        .reg_mask      (reg_mask),
        .sp_in         (sp_in),
        .busy          (busy),
        .done          (done),
        .sp_out        (sp_out),
        .bus           (bus_if.master)
    );

    always #5 clk = ~clk;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          done_cnt = 0;
    int          wait_states = 0;
    int          req_len = 0;
    int          last_req_len = 0;
    ev_t         exp_q[$];
    logic [15:0] mem_m [logic [15:0]];
    logic [15:0] rf_m [8];
    logic [15:0] rf_init [8];
    logic        rf_load = 1'b0;
    logic [32:0] first_req;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem_m.exists(a) ? mem_m[a] : 16'h0000;
    endfunction

    // Register file: one-cycle registered read, synchronous write, bench-side preload.
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf_m[i] <= rf_init[i];
        end else if (bus_if.rf_en && bus_if.rf_wr_en) begin
            rf_m[bus_if.rf_sel] <= bus_if.rf_wdata;
        end
        if (bus_if.rf_en && !bus_if.rf_wr_en) bus_if.rf_rdata <= rf_m[bus_if.rf_sel];
    end

    // Memory responder with wait states, request-stability check and scoreboard pop.
    always @(negedge clk) begin
        ev_t ev;
        ev_t ex;
        logic have_ev;
        have_ev = 1'b0;
        ev = '0;
        if (done) done_cnt++;
        if (bus_if.rf_wr_en) begin
            ev = {2'd3, 13'd0, bus_if.rf_sel, bus_if.rf_wdata};
            have_ev = 1'b1;
        end
        if (bus_if.mem_req) begin
            if (req_len == 0) begin
                first_req = {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata};
            end else begin
                cmp_cnt++;
                if ({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata} !== first_req) begin
                    err_cnt++;
                    $display("FAIL req_stable: got %h required %h",
                             {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata}, first_req);
                end
            end
            req_len++;
            if (req_len > wait_states) begin
                bus_if.mem_ack = 1'b1;
                last_req_len = req_len;
                req_len = 0;
                if (bus_if.mem_we) begin
                    mem_m[bus_if.mem_addr] = bus_if.mem_wdata;
                    ev = {2'd1, bus_if.mem_addr, bus_if.mem_wdata};
                end else begin
                    bus_if.mem_rdata = mem_rd(bus_if.mem_addr);
                    ev = {2'd2, bus_if.mem_addr, bus_if.mem_rdata};
                end
                have_ev = 1'b1;
            end else begin
                bus_if.mem_ack = 1'b0;
            end
        end else begin
            bus_if.mem_ack = 1'b0;
            req_len = 0;
        end
        if (have_ev) begin
            cmp_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_event: got %h required nothing (unexpected transaction)", ev);
            end else begin
                ex = exp_q.pop_front();
                if (ev !== ex) begin
                    err_cnt++;
                    $display("FAIL sb_event: got %h required %h", ev, ex);
                end
            end
        end
    end

    task automatic load_regs();
        rf_load = 1'b1;
        @(negedge clk);
        rf_load = 1'b0;
    endtask

    task automatic exp_save(input logic [7:0] m, input logic [15:0] sp, output logic [15:0] sp_end);
        logic [15:0] s;
        s = sp;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                s = s - 16'd2;
                exp_q.push_back({2'd1, s, rf_m[i]});
            end
        end
        if (FRAME) begin
            s = s - 16'd2;
            exp_q.push_back({2'd1, s, 8'h00, m});
        end
        sp_end = s;
    endtask

    task automatic exp_restore(input logic [7:0] m, input logic [15:0] sp, output logic [15:0] sp_end);
        logic [15:0] s;
        logic [15:0] d;
        logic [7:0]  mm;
        s = sp;
        mm = m;
        if (FRAME) begin
            d = mem_rd(s);
            exp_q.push_back({2'd2, s, d});
            mm = d[7:0];
            s = s + 16'd2;
        end
        for (int i = 0; i < 8; i++) begin
            if (mm[i]) begin
                d = mem_rd(s);
                exp_q.push_back({2'd2, s, d});
                exp_q.push_back({2'd3, 13'd0, 3'(i), d});
                s = s + 16'd2;
            end
        end
        sp_end = s;
    endtask

    // Pulses a start, scrambles the inputs afterwards and returns cycles until done (-1 on timeout).
    task automatic run_op(input bit s, input bit r, input logic [7:0] m, input logic [15:0] sp,
                          input int inject_at, output int lat);
        @(negedge clk);
        start_save = s;
        start_restore = r;
        reg_mask = m;
        sp_in = sp;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_save = 1'b0;
                start_restore = 1'b0;
                reg_mask = 8'($urandom);
                sp_in = 16'($urandom);
            end
            if (c == inject_at) start_restore = 1'b1;
            else if (c == inject_at + 1) start_restore = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [72:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {busy, done, sp_out, bus_if.rf_en, bus_if.rf_wr_en, bus_if.rf_sel, bus_if.rf_wdata,
               bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata};
        cmp_cnt++;
        if (obs !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h required 0", obs);
        end
        rst = 1'b0;
        $display("test_reset: outputs %h", obs);
    endtask

    task automatic test_save_basic(output logic [15:0] sp_end);
        int lat;
        int d0;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'hA0A0 + 16'(i);
        rf_init[0] = 16'h1111;
        rf_init[2] = 16'h2222;
        rf_init[7] = 16'h7777;
        load_regs();
        wait_states = 0;
        d0 = done_cnt;
        exp_save(8'b1000_0101, 16'h0100, sp_end);
        run_op(1'b1, 1'b0, 8'b1000_0101, 16'h0100, 0, lat);
        cmp_cnt++;
        if (lat !== 2 + 3 * 4 + 2 * HDR) begin
            err_cnt++;
            $display("FAIL save_latency: got %0d required %0d", lat, 2 + 3 * 4 + 2 * HDR);
        end
        cmp_cnt++;
        if (sp_out !== sp_end) begin
            err_cnt++;
            $display("FAIL save_sp_out: got %h required %h", sp_out, sp_end);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({busy, done, done_cnt - d0} !== {1'b0, 1'b0, 32'd1}) begin
            err_cnt++;
            $display("FAIL save_done_once: busy %b done %b pulses %0d required 0 0 1",
                     busy, done, done_cnt - d0);
        end
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL save_missing: got %0d pending required 0", exp_q.size());
        end
        $display("test_save_basic: lat %0d sp_out %h", lat, sp_out);
    endtask

    task automatic test_restore_basic(input logic [15:0] sp_start);
        int lat;
        logic [15:0] sp_end;
        logic [127:0] regs_obs;
        logic [127:0] regs_exp;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
        load_regs();
        exp_restore(8'b1000_0101, sp_start, sp_end);
        run_op(1'b0, 1'b1, 8'b1000_0101, sp_start, 0, lat);
        cmp_cnt++;
        if (lat !== 2 + 3 * 3 + 2 * HDR) begin
            err_cnt++;
            $display("FAIL restore_latency: got %0d required %0d", lat, 2 + 3 * 3 + 2 * HDR);
        end
        cmp_cnt++;
        if (sp_out !== 16'h0100) begin
            err_cnt++;
            $display("FAIL restore_sp_out: got %h required 0100", sp_out);
        end
        @(negedge clk);
        regs_obs = {rf_m[7], rf_m[6], rf_m[5], rf_m[4], rf_m[3], rf_m[2], rf_m[1], rf_m[0]};
        regs_exp = {16'h7777, 64'h0, 16'h2222, 16'h0, 16'h1111};
        cmp_cnt++;
        if (regs_obs !== regs_exp) begin
            err_cnt++;
            $display("FAIL restore_regs: got %h required %h", regs_obs, regs_exp);
        end
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL restore_missing: got %0d pending required 0", exp_q.size());
        end
        $display("test_restore_basic: lat %0d sp_out %h model_sp %h", lat, sp_out, sp_end);
    endtask

    task automatic test_empty_mask();
        int lat;
        logic [15:0] sp_end;
        exp_save(8'h00, 16'h1234, sp_end);
        run_op(1'b1, 1'b0, 8'h00, 16'h1234, 0, lat);
        cmp_cnt++;
        if (lat !== 2 + 2 * HDR) begin
            err_cnt++;
            $display("FAIL empty_latency: got %0d required %0d", lat, 2 + 2 * HDR);
        end
        cmp_cnt++;
        if (sp_out !== sp_end) begin
            err_cnt++;
            $display("FAIL empty_sp_out: got %h required %h", sp_out, sp_end);
        end
        @(negedge clk);
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL empty_missing: got %0d pending required 0", exp_q.size());
        end
        $display("test_empty_mask: lat %0d sp_out %h", lat, sp_out);
    endtask

    task automatic test_wait_states();
        int lat;
        logic [15:0] sp_end;
        logic [15:0] sp_back;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
        rf_init[0] = 16'hBEEF;
        load_regs();
        wait_states = 3;
        exp_save(8'h01, 16'h0000, sp_end);
        run_op(1'b1, 1'b0, 8'h01, 16'h0000, 0, lat);
        cmp_cnt++;
        if (lat !== 2 + 7 + 5 * HDR) begin
            err_cnt++;
            $display("FAIL wait_save_latency: got %0d required %0d", lat, 2 + 7 + 5 * HDR);
        end
        cmp_cnt++;
        if ({sp_out, 32'(last_req_len)} !== {sp_end, 32'd4}) begin
            err_cnt++;
            $display("FAIL wait_save_sp_len: got %h/%0d required %h/4", sp_out, last_req_len, sp_end);
        end
        rf_init[0] = 16'h0000;
        load_regs();
        exp_restore(8'h01, sp_end, sp_back);
        run_op(1'b0, 1'b1, 8'h01, sp_end, 0, lat);
        cmp_cnt++;
        if (lat !== 2 + 6 + 5 * HDR) begin
            err_cnt++;
            $display("FAIL wait_restore_latency: got %0d required %0d", lat, 2 + 6 + 5 * HDR);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({sp_out, rf_m[0]} !== {16'h0000, 16'hBEEF}) begin
            err_cnt++;
            $display("FAIL wait_restore_wrap: got sp %h r0 %h required sp 0000 r0 beef", sp_out, rf_m[0]);
        end
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL wait_missing: got %0d pending required 0", exp_q.size());
        end
        wait_states = 0;
        $display("test_wait_states: save_end %h restore_end %h", sp_end, sp_out);
    endtask

    task automatic test_priority_busy();
        int lat;
        int d0;
        logic busy_seen;
        logic [15:0] sp_end;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
        rf_init[1] = 16'h1010;
        rf_init[2] = 16'h2020;
        load_regs();
        d0 = done_cnt;
        exp_save(8'h06, 16'h0300, sp_end);
        run_op(1'b1, 1'b1, 8'h06, 16'h0300, 5, lat);
        cmp_cnt++;
        if ({32'(lat), sp_out} !== {32'(2 + 8 + 2 * HDR), sp_end}) begin
            err_cnt++;
            $display("FAIL prio_save: got lat %0d sp %h required lat %0d sp %h",
                     lat, sp_out, 2 + 8 + 2 * HDR, sp_end);
        end
        busy_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        cmp_cnt++;
        if ({busy_seen, done_cnt - d0} !== {1'b0, 32'd1}) begin
            err_cnt++;
            $display("FAIL prio_ignored_start: busy_after %b pulses %0d required 0 1",
                     busy_seen, done_cnt - d0);
        end
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL prio_missing: got %0d pending required 0", exp_q.size());
        end
        $display("test_priority_busy: lat %0d sp_out %h", lat, sp_out);
    endtask

    task automatic test_reset_mid();
        int d0;
        bit found;
        wait_states = 50;
        d0 = done_cnt;
        found = 1'b0;
        @(negedge clk);
        start_save = 1'b1;
        reg_mask = 8'h80;
        sp_in = 16'h0400;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start_save = 1'b0;
            if (bus_if.mem_req && bus_if.mem_we) begin
                found = 1'b1;
                break;
            end
        end
        cmp_cnt++;
        if (found !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_mid_reach: got %b required 1", found);
        end
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if ({bus_if.mem_req, busy, done} !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_mid_abort: got %b required 000", {bus_if.mem_req, busy, done});
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        cmp_cnt++;
        if ({bus_if.mem_req, busy, done_cnt - d0} !== {2'b00, 32'd0}) begin
            err_cnt++;
            $display("FAIL reset_mid_quiet: req %b busy %b pulses %0d required 0 0 0",
                     bus_if.mem_req, busy, done_cnt - d0);
        end
        wait_states = 0;
        $display("test_reset_mid: aborted save, pulses %0d", done_cnt - d0);
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        logic [7:0]  m;
        logic [15:0] sp;
        logic [15:0] sp_end;
        logic [15:0] sp_back;
        logic [15:0] snap [8];
        for (int k = 0; k < 4; k++) begin
            m = 8'($urandom_range(1, 255));
            sp = 16'($urandom) & 16'hFFFE;
            wait_states = $urandom_range(0, 2);
            n = $countones(m);
            for (int i = 0; i < 8; i++) begin
                rf_init[i] = 16'($urandom);
                snap[i] = rf_init[i];
            end
            load_regs();
            exp_save(m, sp, sp_end);
            run_op(1'b1, 1'b0, m, sp, 0, lat);
            cmp_cnt++;
            if ({32'(lat), sp_out} !== {32'(2 + (4 + wait_states) * n + (2 + wait_states) * HDR), sp_end}) begin
                err_cnt++;
                $display("FAIL b2b_save: got lat %0d sp %h required lat %0d sp %h", lat, sp_out,
                         2 + (4 + wait_states) * n + (2 + wait_states) * HDR, sp_end);
            end
            for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
            load_regs();
            exp_restore(m, sp_end, sp_back);
            run_op(1'b0, 1'b1, m, sp_end, 0, lat);
            cmp_cnt++;
            if ({32'(lat), sp_out} !== {32'(2 + (3 + wait_states) * n + (2 + wait_states) * HDR), sp}) begin
                err_cnt++;
                $display("FAIL b2b_restore: got lat %0d sp %h required lat %0d sp %h", lat, sp_out,
                         2 + (3 + wait_states) * n + (2 + wait_states) * HDR, sp);
            end
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                cmp_cnt++;
                if (rf_m[i] !== (m[i] ? snap[i] : 16'h0000)) begin
                    err_cnt++;
                    $display("FAIL b2b_reg%0d: got %h required %h", i, rf_m[i], m[i] ? snap[i] : 16'h0000);
                end
            end
            cmp_cnt++;
            if (exp_q.size() != 0) begin
                err_cnt++;
                $display("FAIL b2b_missing: got %0d pending required 0", exp_q.size());
            end
            $display("test_back_to_back: iter %0d mask %h sp %h waits %0d end %h", k, m, sp, wait_states, sp_end);
        end
        wait_states = 0;
    endtask

`ifdef CTX_FRAME_WORD_EN
    task automatic test_frame();
        int lat;
        logic [15:0] sp_end;
        logic [15:0] sp_back;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
        rf_init[0] = 16'h0A0A;
        rf_init[1] = 16'h1B1B;
        load_regs();
        exp_save(8'h03, 16'h0200, sp_end);
        run_op(1'b1, 1'b0, 8'h03, 16'h0200, 0, lat);
        @(negedge clk);
        cmp_cnt++;
        if ({sp_out, mem_rd(16'h01FA)} !== {16'h01FA, 16'h0003}) begin
            err_cnt++;
            $display("FAIL frame_header: got sp %h hdr %h required 01fa 0003", sp_out, mem_rd(16'h01FA));
        end
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
        load_regs();
        exp_restore(8'h00, 16'h01FA, sp_back);
        run_op(1'b0, 1'b1, 8'h00, 16'h01FA, 0, lat);
        @(negedge clk);
        cmp_cnt++;
        if ({sp_out, rf_m[1], rf_m[0]} !== {16'h0200, 16'h1B1B, 16'h0A0A}) begin
            err_cnt++;
            $display("FAIL frame_restore: got sp %h r1 %h r0 %h required 0200 1b1b 0a0a",
                     sp_out, rf_m[1], rf_m[0]);
        end
        $display("test_frame: restore sp_out %h", sp_out);
    endtask
`endif

    initial begin
        logic [15:0] saved_sp;
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = 16'h0000;
        bus_if.rf_rdata = 16'h0000;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
        test_reset();
        load_regs();
        test_save_basic(saved_sp);
        test_restore_basic(saved_sp);
        test_empty_mask();
        test_wait_states();
        test_priority_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef CTX_FRAME_WORD_EN
        test_frame();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
